conway_row_scanner: RTL and testbench
=====================================

Name: conway_row_scanner

Overview:
Downstream display stage for the Game of Life grid. Snapshots the packed state_q vector of all cells once per frame and time-multiplexes it onto a row-scanned LED matrix, with a dwell and blanking interval per row. Also generates the one-cycle step pulse that drives the cells' ena input, so generation rate is locked to the display frame rate.

Parameters:
ROWS, 8, number of grid rows (>=2)
COLS, 8, number of grid columns (>=1)
DWELL_CYCLES, 1000, cycles each row is lit (>=1)
BLANK_CYCLES, 16, all-off cycles before each row is lit (>=1)
FRAMES_PER_STEP, 30, display frames per generation step (>=1)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-low reset (0 = in reset)
ena  input  1  scanner enable; 0 = pause and blank
cells  input  ROWS*COLS  packed cell states; cell (r,c) = cells[r*COLS+c]
rows  output  ROWS  one-hot row select, active-high
cols  output  COLS  column drive, active-low (0 = LED on)
frame_start  output  1  one-cycle pulse on first lit cycle of row 0
step  output  1  one-cycle pulse; connect to conway cell ena

Behaviour:
- All outputs registered; they change only on posedge clk or async reset.
- Reset (rst=0, async): rows=0, cols=all 1, frame_start=0, step=0, state=BLANK, row_idx=0, cycle counter=0, frame counter=0, snapshot=0. Takes effect immediately mid-frame; after release, first lit cycle of row 0 comes BLANK_CYCLES cycles later.
- FSM, two states:
  - BLANK: rows=0, cols=all 1. Stays exactly BLANK_CYCLES cycles, then SHOW.
  - SHOW: rows = one-hot(row_idx); cols[c] = ~snapshot[row_idx*COLS+c]. Stays exactly DWELL_CYCLES cycles, then BLANK with row_idx+1; ROWS-1 wraps to 0.
- Row period = BLANK_CYCLES+DWELL_CYCLES; frame = ROWS*row period.
- Snapshot: cells latched on the BLANK->SHOW edge when row_idx==0 (same edge raises frame_start). cells changes at any other time have no visible effect until the next frame.
- Frame counter: increments on the SHOW->BLANK edge of row ROWS-1. When it equals FRAMES_PER_STEP-1 on that edge, it clears to 0 and step is asserted for exactly that one following cycle. FRAMES_PER_STEP=1 gives step every frame.
- step and frame_start never assert on consecutive frames' same cycle except by rule above. Both are deasserted while ena=0 or in reset.
- ena=0: FSM, row_idx, cycle and frame counters, and snapshot all hold. Outputs are forced blank (rows=0, cols=all 1) on the next edge. When ena returns to 1, scanning resumes in the held state with the remaining dwell/blank count. Pause time is not counted, so the step period grows by the pause length.
- Counter widths are $clog2 of each max count, minimum 1 bit. No overflow beyond parameter maxima.
- Simultaneous: reset dominates ena; ena=0 on the cycle a step would fire suppresses it until the edge actually occurs after resume.

Test Plan:
(Params for all: ROWS=4, COLS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, FRAMES_PER_STEP=2; row period 6, frame 24, step period 48.)
1. Reset: hold rst=0, then release. rows=0, cols=4'hF, step=0 during reset. First frame_start and rows=4'b0001 arrive 2 cycles after release. Reassert rst mid-SHOW: outputs blank in same cycle, no clock needed.
2. Pattern: cells=16'h8421. Rows 0..3 show cols=4'hE, 4'hD, 4'hB, 4'h7. Each is lit 4 cycles, with 2 blank cycles (rows=0, cols=4'hF) before each.
3. Snapshot isolation: cells=16'hFFFF before frame, then 16'h0000 during row 1. Rows 1-3 still show cols=4'h0 for that frame; next frame shows 4'hF on all rows.
4. Step cadence: free-run 200 cycles. step is 1 cycle wide, every 48 cycles, on the cycle after row 3 SHOW ends in every second frame. frame_start is every 24 cycles.
5. Pause: ena=0 for 10 cycles after 1 cycle of row 2 SHOW. Outputs blank during the pause. On resume, row 2 lit 3 more cycles, and the next step is delayed by exactly 10 cycles.
6. Wrap/edge: FRAMES_PER_STEP=1, run 3 frames. step fires every 24 cycles, row_idx wraps 3->0 cleanly, and no row is ever lit for more or fewer than 4 cycles.

Source files
------------

// File: rtl/conway_row_scanner.sv
// Row-scanned LED matrix driver for the Game of Life grid. It latches the cell
// vector once per frame and emits the generation step pulse on frame boundaries.
module conway_row_scanner #(
    parameter int ROWS            = 8,
    parameter int COLS            = 8,
    parameter int DWELL_CYCLES    = 1000,
    parameter int BLANK_CYCLES    = 16,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [ROWS*COLS-1:0]   cells,
    output logic [ROWS-1:0]        rows,
    output logic [COLS-1:0]        cols,
    output logic                   frame_start,
    output logic                   step
);

    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW      = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [RW-1:0] ROW_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_ONE    = RW'(1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [FW-1:0] FRM_ZERO   = {FW{1'b0}};
    localparam logic [FW-1:0] FRM_ONE    = FW'(1);
    localparam logic [FW-1:0] FRM_LAST   = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          row_q, row_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [ROWS*COLS-1:0]   snap_q, snap_d;

    logic                   show_start_s;
    logic                   step_fire_s;

    logic [ROWS-1:0]        rows_q, rows_d;
    logic [COLS-1:0]        cols_q, cols_d;
    logic                   frame_start_q, frame_start_d;
    logic                   step_q, step_d;

    // State register: scan position, frame count and the frame snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= CNT_ZERO;
            row_q   <= ROW_ZERO;
            frame_q <= FRM_ZERO;
            snap_q  <= {(ROWS*COLS){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state logic; everything holds while ena is low so pauses are not counted
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        frame_d      = frame_q;
        snap_d       = snap_q;
        show_start_s = 1'b0;
        step_fire_s  = 1'b0;
        if (ena) begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d      = ST_SHOW;
                        cnt_d        = CNT_ZERO;
                        show_start_s = 1'b1;
                        if (row_q == ROW_ZERO) begin
                            snap_d = cells;
                        end else begin
                            snap_d = snap_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = CNT_ZERO;
                        if (row_q == ROW_LAST) begin
                            row_d = ROW_ZERO;
                            // Last row closes the frame; the step pulse rides on that edge
                            if (frame_q == FRM_LAST) begin
                                frame_d     = FRM_ZERO;
                                step_fire_s = 1'b1;
                            end else begin
                                frame_d = frame_q + FRM_ONE;
                            end
                        end else begin
                            row_d = row_q + ROW_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode from the upcoming state so the registered outputs track it exactly
    always_comb begin
        rows_d        = {ROWS{1'b0}};
        cols_d        = {COLS{1'b1}};
        frame_start_d = 1'b0;
        step_d        = 1'b0;
        if (ena && (state_d == ST_SHOW)) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_d == RW'(r)) begin
                    rows_d[r] = 1'b1;
                    cols_d    = ~snap_d[r*COLS +: COLS];
                end else begin
                    rows_d[r] = 1'b0;
                end
            end
        end else begin
            rows_d = {ROWS{1'b0}};
            cols_d = {COLS{1'b1}};
        end
        frame_start_d = show_start_s && (row_q == ROW_ZERO);
        step_d        = step_fire_s;
    end

    // Output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_q        <= {ROWS{1'b0}};
            cols_q        <= {COLS{1'b1}};
            frame_start_q <= 1'b0;
            step_q        <= 1'b0;
        end else begin
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            frame_start_q <= frame_start_d;
            step_q        <= step_d;
        end
    end

    assign rows        = rows_q;
    assign cols        = cols_q;
    assign frame_start = frame_start_q;
    assign step        = step_q;

endmodule

// File: tb/tb_conway_row_scanner.sv
// Self-checking bench for conway_row_scanner: a cycle-position reference model
// (enabled edge count modulo frame/step periods) checked against two instances.
module tb_conway_row_scanner;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DWELL  = 4;
    localparam int BLANK  = 2;
    localparam int PERIOD = BLANK + DWELL;
    localparam int FRAME  = ROWS * PERIOD;
    localparam int STEP_P = 2 * FRAME;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        ena   = 1'b1;
    logic [15:0] cells = 16'h0000;
    logic [3:0]  rows, cols, rows1, cols1;
    logic        frame_start, step, frame_start1, step1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          a = 0;
    int          pos = 0;
    int          tick_n = 0;
    logic [15:0] snap = 16'h0000;
    logic [3:0]  exp_rows = 4'h0;
    logic [3:0]  exp_cols = 4'hF;
    logic        exp_fs = 1'b0;
    logic        exp_step = 1'b0;
    logic        exp_step1 = 1'b0;

    always #5 clk = ~clk;

    conway_row_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL),
                         .BLANK_CYCLES(BLANK), .FRAMES_PER_STEP(2)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .cells(cells),
        .rows(rows), .cols(cols), .frame_start(frame_start), .step(step));

    conway_row_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL),
                         .BLANK_CYCLES(BLANK), .FRAMES_PER_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .ena(ena), .cells(cells),
        .rows(rows1), .cols(cols1), .frame_start(frame_start1), .step(step1));

    // One clock edge; the model counts enabled edges since reset and derives
    // the expected outputs from the position within the frame.
    task automatic tick();
        logic       en_now;
        int         r;
        logic [3:0] one_row;
        @(posedge clk);
        en_now = rst && ena;
        tick_n++;
        if (!rst) begin
            a    = 0;
            snap = 16'h0000;
        end else if (ena) begin
            a++;
            if ((a % FRAME) == BLANK) snap = cells;
        end
        pos     = a % FRAME;
        r       = pos / PERIOD;
        one_row = 4'b0001;
        if (en_now && ((pos % PERIOD) >= BLANK)) begin
            exp_rows = one_row << r;
            exp_cols = ~snap[r*COLS +: COLS];
        end else begin
            exp_rows = 4'h0;
            exp_cols = 4'hF;
        end
        exp_fs    = en_now && (pos == BLANK);
        exp_step  = en_now && ((a % STEP_P) == 0);
        exp_step1 = en_now && (pos == 0);
        #1;
    endtask

    task automatic run_to(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2*FRAME && !ok; i++) begin
            tick();
            if (pos == target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; cells = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rows !== 4'h0 || cols !== 4'hF || step !== 1'b0 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold rows %h cols %h step %b fs %b, required 0 F 0 0", rows, cols, step, frame_start);
            end
        end
        cells = 16'h8421;
        rst = 1'b1;
        tick();
        checks++;
        if (rows !== 4'h0 || cols !== 4'hF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL release_blank rows %h cols %h fs %b, required 0 F 0", rows, cols, frame_start);
        end
        tick();
        checks++;
        if (rows !== 4'b0001 || cols !== 4'hE || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL first_lit rows %h cols %h fs %b, required 1 E 1", rows, cols, frame_start);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rows !== 4'h0 || cols !== 4'hF || frame_start !== 1'b0 || step !== 1'b0) begin
            errors++;
            $display("FAIL async_reset rows %h cols %h fs %b step %b, required 0 F 0 0", rows, cols, frame_start, step);
        end
        a = 0; snap = 16'h0000;
        tick();
    endtask

    task automatic test_pattern();
        logic [3:0] pat [4];
        int lit_cnt [4];
        int blank_cnt;
        pat = '{4'hE, 4'hD, 4'hB, 4'h7};
        lit_cnt = '{0, 0, 0, 0};
        blank_cnt = 0;
        cells = 16'h8421;
        rst = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if (rows !== exp_rows || cols !== exp_cols || frame_start !== exp_fs || step !== exp_step) begin
                errors++;
                $display("FAIL pattern_model t=%0d rows %h exp %h cols %h exp %h fs %b exp %b step %b exp %b",
                         tick_n, rows, exp_rows, cols, exp_cols, frame_start, exp_fs, step, exp_step);
            end
            if ((pos % PERIOD) >= BLANK) begin
                lit_cnt[pos/PERIOD]++;
                checks++;
                if (cols !== pat[pos/PERIOD]) begin
                    errors++;
                    $display("FAIL pattern_cols row %0d cols %h, required %h", pos/PERIOD, cols, pat[pos/PERIOD]);
                end
            end else begin
                if (rows === 4'h0 && cols === 4'hF) blank_cnt++;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (lit_cnt[r] != DWELL) begin
                errors++;
                $display("FAIL pattern_dwell row %0d lit %0d, required %0d", r, lit_cnt[r], DWELL);
            end
        end
        checks++;
        if (blank_cnt != ROWS*BLANK) begin
            errors++;
            $display("FAIL pattern_blank count %0d, required %0d", blank_cnt, ROWS*BLANK);
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        cells = 16'hFFFF;
        run_to(BLANK, ok);
        checks++;
        if (!ok || cols !== 4'h0 || rows !== 4'b0001) begin
            errors++;
            $display("FAIL snap_frame_start reached %b rows %h cols %h, required 1 1 0", ok, rows, cols);
        end
        run_to(PERIOD + BLANK, ok);
        cells = 16'h0000;
        for (int i = 0; i < FRAME && pos != 0; i++) begin
            tick();
            checks++;
            if (rows !== exp_rows || cols !== exp_cols || frame_start !== exp_fs || step !== exp_step) begin
                errors++;
                $display("FAIL snap_model t=%0d rows %h exp %h cols %h exp %h fs %b exp %b step %b exp %b",
                         tick_n, rows, exp_rows, cols, exp_cols, frame_start, exp_fs, step, exp_step);
            end
            if (exp_rows != 4'h0 && cols !== 4'h0) begin
                errors++;
                $display("FAIL snap_isolation rows %h cols %h, required 0", rows, cols);
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (exp_rows != 4'h0) begin
                checks++;
                if (cols !== 4'hF || rows !== exp_rows) begin
                    errors++;
                    $display("FAIL snap_next_frame rows %h exp %h cols %h, required F", rows, exp_rows, cols);
                end
            end
        end
    endtask

    task automatic test_step_cadence();
        int last_step = -1;
        int last_fs = -1;
        int nsteps = 0;
        int nfs = 0;
        for (int i = 0; i < 200; i++) begin
            cells = 16'($urandom());
            tick();
            checks++;
            if (rows !== exp_rows || cols !== exp_cols || frame_start !== exp_fs || step !== exp_step) begin
                errors++;
                $display("FAIL cadence_model t=%0d rows %h exp %h cols %h exp %h fs %b exp %b step %b exp %b",
                         tick_n, rows, exp_rows, cols, exp_cols, frame_start, exp_fs, step, exp_step);
            end
            if (step === 1'b1) begin
                if (last_step >= 0) begin
                    checks++;
                    if (tick_n - last_step != STEP_P) begin
                        errors++;
                        $display("FAIL step_period got %0d, required %0d", tick_n - last_step, STEP_P);
                    end
                end
                last_step = tick_n;
                nsteps++;
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (tick_n - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d, required %0d", tick_n - last_fs, FRAME);
                    end
                end
                last_fs = tick_n;
                nfs++;
            end
        end
        checks++;
        if (nsteps < 4 || nfs < 8) begin
            errors++;
            $display("FAIL cadence_count steps %0d frames %0d, required >=4 >=8", nsteps, nfs);
        end
    endtask

    task automatic test_pause();
        bit ok;
        int nominal, t0, lit;
        run_to(2*PERIOD + BLANK, ok);
        checks++;
        if (!ok || rows !== 4'b0100) begin
            errors++;
            $display("FAIL pause_setup reached %b rows %h, required 1 4", ok, rows);
        end
        nominal = STEP_P - (a % STEP_P);
        t0 = tick_n;
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (rows !== 4'h0 || cols !== 4'hF || step !== 1'b0 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL pause_blank rows %h cols %h step %b fs %b, required 0 F 0 0", rows, cols, step, frame_start);
            end
        end
        ena = 1'b1;
        lit = 0;
        tick();
        while (rows === 4'b0100 && lit < 10) begin
            lit++;
            tick();
        end
        checks++;
        if (lit != DWELL - 1) begin
            errors++;
            $display("FAIL pause_resume_dwell lit %0d, required %0d", lit, DWELL - 1);
        end
        for (int i = 0; i < 2*STEP_P && step !== 1'b1; i++) tick();
        checks++;
        if (step !== 1'b1 || (tick_n - t0) != nominal + 10) begin
            errors++;
            $display("FAIL pause_step_delay step %b after %0d, required 1 after %0d", step, tick_n - t0, nominal + 10);
        end
    endtask

    task automatic test_random_ena();
        for (int i = 0; i < 300; i++) begin
            ena = ($urandom_range(3, 0) != 0);
            cells = 16'($urandom());
            tick();
            checks++;
            if (rows !== exp_rows || cols !== exp_cols || frame_start !== exp_fs || step !== exp_step) begin
                errors++;
                $display("FAIL rand_ena_model t=%0d rows %h exp %h cols %h exp %h fs %b exp %b step %b exp %b",
                         tick_n, rows, exp_rows, cols, exp_cols, frame_start, exp_fs, step, exp_step);
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_wrap();
        logic [3:0] run_row, last_row, want;
        int run_len, nsteps;
        run_row = 4'h0; last_row = 4'h0; run_len = 0; nsteps = 0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3*FRAME; i++) begin
            cells = 16'($urandom());
            tick();
            checks++;
            if (rows1 !== exp_rows || cols1 !== exp_cols || frame_start1 !== exp_fs || step1 !== exp_step1) begin
                errors++;
                $display("FAIL wrap_model t=%0d rows %h exp %h cols %h exp %h fs %b exp %b step %b exp %b",
                         tick_n, rows1, exp_rows, cols1, exp_cols, frame_start1, exp_fs, step1, exp_step1);
            end
            if (step1 === 1'b1) nsteps++;
            if (rows1 !== 4'h0 && rows1 === run_row) begin
                run_len++;
            end else begin
                if (run_row != 4'h0) begin
                    checks++;
                    if (run_len != DWELL) begin
                        errors++;
                        $display("FAIL wrap_run row %h lit %0d, required %0d", run_row, run_len, DWELL);
                    end
                    last_row = run_row;
                end
                run_row = rows1;
                run_len = 1;
                if (rows1 !== 4'h0) begin
                    want = (last_row == 4'h0 || last_row == 4'b1000) ? 4'b0001 : (last_row << 1);
                    checks++;
                    if (rows1 !== want) begin
                        errors++;
                        $display("FAIL wrap_order rows %h, required %h", rows1, want);
                    end
                end
            end
        end
        checks++;
        if (nsteps != 3) begin
            errors++;
            $display("FAIL wrap_steps got %0d, required 3", nsteps);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at tick %0d", tick_n);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pattern();
        test_snapshot();
        test_step_cadence();
        test_pause();
        test_random_ena();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
